// File: rtl/tpx3_tx_pkg.sv
// Shared constants and types for the Timepix3 DataOut lane transmitter.
package tpx3_tx_pkg;

    localparam int unsigned SYMBOL_BITS = 10;

    // K28.5 comma, abcdei fghj with bit 'a' in the MSB
    localparam logic [SYMBOL_BITS-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [SYMBOL_BITS-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        StSync,
        StIdle,
        StSend
    } tx_state_e;

endpackage

// File: rtl/enc_8b10b.sv
// Combinational IBM 8b10b encoder; rd_in/rd_out: 0 = RD-, 1 = RD+. code[9] is bit 'a'.
module enc_8b10b (
    input  logic [7:0] data,
    input  logic       k,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] six_n;
    logic [5:0] six;
    logic [3:0] four_n;
    logic [3:0] four;
    logic       unbal6;
    logic       unbal4;
    logic       rd_mid;
    logic       use_a7;

    assign x = data[4:0];
    assign y = data[7:5];

    always_comb begin
        unique case (x)
            5'd0:    six_n = 6'b100111;
            5'd1:    six_n = 6'b011101;
            5'd2:    six_n = 6'b101101;
            5'd3:    six_n = 6'b110001;
            5'd4:    six_n = 6'b110101;
            5'd5:    six_n = 6'b101001;
            5'd6:    six_n = 6'b011001;
            5'd7:    six_n = 6'b111000;
            5'd8:    six_n = 6'b111001;
            5'd9:    six_n = 6'b100101;
            5'd10:   six_n = 6'b010101;
            5'd11:   six_n = 6'b110100;
            5'd12:   six_n = 6'b001101;
            5'd13:   six_n = 6'b101100;
            5'd14:   six_n = 6'b011100;
            5'd15:   six_n = 6'b010111;
            5'd16:   six_n = 6'b011011;
            5'd17:   six_n = 6'b100011;
            5'd18:   six_n = 6'b010011;
            5'd19:   six_n = 6'b110010;
            5'd20:   six_n = 6'b001011;
            5'd21:   six_n = 6'b101010;
            5'd22:   six_n = 6'b011010;
            5'd23:   six_n = 6'b111010;
            5'd24:   six_n = 6'b110011;
            5'd25:   six_n = 6'b100110;
            5'd26:   six_n = 6'b010110;
            5'd27:   six_n = 6'b110110;
            5'd28:   six_n = 6'b001110;
            5'd29:   six_n = 6'b101110;
            5'd30:   six_n = 6'b011110;
            default: six_n = 6'b101011;
        endcase
        if (k && x == 5'd28) six_n = 6'b001111;
        unbal6 = ($countones(six_n) != 3);

        // D.7 is balanced but still has distinct RD- / RD+ forms
        if (x == 5'd7 && !k) begin
            six    = rd_in ? 6'b000111 : 6'b111000;
            rd_mid = rd_in;
        end else begin
            six    = (rd_in && unbal6) ? ~six_n : six_n;
            rd_mid = rd_in ^ unbal6;
        end

        use_a7 = k || (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20))
                   || ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));

        unique case (y)
            3'd0:    four_n = 4'b1011;
            3'd1:    four_n = 4'b1001;
            3'd2:    four_n = 4'b0101;
            3'd3:    four_n = 4'b1100;
            3'd4:    four_n = 4'b1101;
            3'd5:    four_n = 4'b1010;
            3'd6:    four_n = 4'b0110;
            default: four_n = use_a7 ? 4'b0111 : 4'b1110;
        endcase
        unbal4 = ($countones(four_n) != 2);

        // K28.y flips its balanced fghj when the 6b block left RD negative
        if (y == 3'd3) begin
            four = rd_mid ? 4'b0011 : 4'b1100;
        end else if (unbal4) begin
            four = rd_mid ? ~four_n : four_n;
        end else begin
            four = (k && !rd_mid) ? ~four_n : four_n;
        end

        rd_out = rd_mid ^ unbal4;
        code   = {six, four};
    end

endmodule

// File: rtl/tpx3_dataout_tx.sv
// Timepix3 DataOut lane transmitter: 48-bit packets -> 8b10b serial stream with K28.5 idle fill.
// Optional build macro TX_ERR_INJECT_EN adds ERR_INJECT/ERR_INJECTED for bit-'a' corruption.
module tpx3_dataout_tx
    import tpx3_tx_pkg::*;
#(
    parameter int unsigned N_BYTES   = 6,
    parameter int unsigned IDLE_MIN  = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [8*N_BYTES-1:0]   PKT_DATA,
    input  logic                   PKT_VALID,
    output logic                   PKT_READY,
    output logic                   SER_OUT,
    output logic                   SYMBOL_START,
    output logic                   SYNC_DONE,
    output logic [CNT_WIDTH-1:0]   PKT_CNT
`ifdef TX_ERR_INJECT_EN
    ,
    input  logic                   ERR_INJECT,
    output logic                   ERR_INJECTED
`endif
);

    localparam int unsigned IdxW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_BYTES - 1);
    localparam logic [3:0] LastBit = 4'(SYMBOL_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [3:0]             bit_cnt_q;
    logic [7:0]             idle_cnt_q, idle_cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d, ld_idx;
    logic [8*N_BYTES-1:0]   pkt_q;
    logic                   pkt_full_q, pkt_full_d;
    logic                   rd_q, rd_next, enc_rd;
    logic [SYMBOL_BITS-1:0] sr_q, sym_code, sym_tx, enc_code;
    logic                   sym_start_q;
    logic                   sync_done_q, sync_done_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   boundary, send_byte, capture;
    logic [7:0]             cur_byte;

    assign boundary  = (bit_cnt_q == LastBit);
    assign PKT_READY = !pkt_full_q && !RST;
    assign capture   = PKT_VALID && PKT_READY;
    assign cur_byte  = pkt_q[8*ld_idx +: 8];

    enc_8b10b u_enc (
        .data   (cur_byte),
        .k      (1'b0),
        .rd_in  (rd_q),
        .code   (enc_code),
        .rd_out (enc_rd)
    );

    // Commas come straight from the constants; K28.5 is unbalanced so RD always flips
    assign sym_code = send_byte ? enc_code : (rd_q ? K28_5_RDP : K28_5_RDN);
    assign rd_next  = send_byte ? enc_rd : !rd_q;

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        idx_d       = idx_q;
        pkt_full_d  = pkt_full_q;
        cnt_d       = cnt_q;
        sync_done_d = sync_done_q;
        send_byte   = 1'b0;
        ld_idx      = LastIdx;

        if (boundary) begin
            unique case (state_q)
                StSync: begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                    if (idle_cnt_q == 8'(IDLE_MIN - 1)) begin
                        sync_done_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
                StIdle: send_byte = pkt_full_q;
                StSend: begin
                    send_byte = 1'b1;
                    ld_idx    = idx_q;
                end
                default: state_d = StSync;
            endcase

            if (send_byte) begin
                if (ld_idx == '0) begin
                    pkt_full_d = 1'b0;
                    cnt_d      = cnt_q + CNT_WIDTH'(1);
                    state_d    = StIdle;
                end else begin
                    idx_d   = ld_idx - IdxW'(1);
                    state_d = StSend;
                end
            end
        end

        if (capture) pkt_full_d = 1'b1;
    end

`ifdef TX_ERR_INJECT_EN
    logic inj_prev_q, inj_armed_q, inj_pulse_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            inj_prev_q  <= 1'b0;
            inj_armed_q <= 1'b0;
            inj_pulse_q <= 1'b0;
        end else begin
            inj_prev_q  <= ERR_INJECT;
            inj_pulse_q <= boundary && inj_armed_q;
            if (boundary) inj_armed_q <= 1'b0;
            if (ERR_INJECT && !inj_prev_q) inj_armed_q <= 1'b1;
        end
    end

    // RD tracking stays on the clean code; only the line sees the flipped bit
    assign sym_tx       = sym_code ^ {inj_armed_q, {(SYMBOL_BITS-1){1'b0}}};
    assign ERR_INJECTED = inj_pulse_q;
`else
    assign sym_tx = sym_code;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StSync;
            bit_cnt_q   <= LastBit;
            idle_cnt_q  <= '0;
            idx_q       <= '0;
            pkt_full_q  <= 1'b0;
            rd_q        <= 1'b0;
            sr_q        <= '0;
            sym_start_q <= 1'b0;
            sync_done_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= boundary ? 4'd0 : bit_cnt_q + 4'd1;
            idle_cnt_q  <= idle_cnt_d;
            idx_q       <= idx_d;
            pkt_full_q  <= pkt_full_d;
            sym_start_q <= boundary;
            sync_done_q <= sync_done_d;
            cnt_q       <= cnt_d;
            if (boundary) begin
                sr_q <= sym_tx;
                rd_q <= rd_next;
            end else begin
                sr_q <= {sr_q[SYMBOL_BITS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (capture) pkt_q <= PKT_DATA;
    end

    assign SER_OUT      = sr_q[SYMBOL_BITS-1];
    assign SYMBOL_START = sym_start_q;
    assign SYNC_DONE    = sync_done_q;
    assign PKT_CNT      = cnt_q;

endmodule

// File: tb/tb_tpx3_dataout_tx.sv
// Bench for tpx3_dataout_tx: serial monitor with a reference 8b10b decoder and byte scoreboard.
module tb_tpx3_dataout_tx;

    logic        CLK = 1'b0;
    logic        RST;
    logic [47:0] PKT_DATA;
    logic        PKT_VALID;
    logic        PKT_READY;
    logic        SER_OUT;
    logic        SYMBOL_START;
    logic        SYNC_DONE;
    logic [3:0]  PKT_CNT;

    tpx3_dataout_tx #(
        .N_BYTES   (6),
        .IDLE_MIN  (2),
        .CNT_WIDTH (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .PKT_DATA     (PKT_DATA),
        .PKT_VALID    (PKT_VALID),
        .PKT_READY    (PKT_READY),
        .SER_OUT      (SER_OUT),
        .SYMBOL_START (SYMBOL_START),
        .SYNC_DONE    (SYNC_DONE),
        .PKT_CNT      (PKT_CNT)
    );

    always #5 CLK = ~CLK;

    // RD- forms of the 5b/6b and 3b/4b sub-blocks
    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    localparam logic [3:0] T4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    logic [9:0] m_code;
    int         m_nb      = 0;
    bit         m_started = 0;
    logic       m_rd      = 1'b0;
    int         run_len   = 0;
    int         last_run  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void decode(input logic [9:0] c, input logic rd, output logic [7:0] b,
                                   output logic err, output logic nrd);
        logic [5:0] s6;
        logic [3:0] s4;
        logic       r;
        int         x;
        int         y;
        s6  = c[9:4];
        s4  = c[3:0];
        err = 1'b0;
        x   = -1;
        y   = -1;
        r   = rd;
        if (s6 == 6'b111000) begin
            x = 7; err |= rd;
        end else if (s6 == 6'b000111) begin
            x = 7; err |= !rd;
        end else if ($countones(s6) == 3) begin
            for (int i = 0; i < 32; i++) if (T6[i] == s6 && $countones(T6[i]) == 3) x = i;
        end else if ($countones(s6) == 4) begin
            err |= rd; r = 1'b1;
            for (int i = 0; i < 32; i++) if (T6[i] == s6) x = i;
        end else if ($countones(s6) == 2) begin
            err |= !rd; r = 1'b0;
            for (int i = 0; i < 32; i++) if (~T6[i] == s6) x = i;
        end
        nrd = r;
        if (s4 == 4'b1100) begin
            y = 3; err |= r;
        end else if (s4 == 4'b0011) begin
            y = 3; err |= !r;
        end else if ($countones(s4) == 2) begin
            for (int j = 0; j < 8; j++) if (j != 3 && T4[j] == s4 && $countones(T4[j]) == 2) y = j;
        end else if ($countones(s4) == 3) begin
            err |= r; nrd = 1'b1;
            if (s4 == 4'b0111) y = 7;
            for (int j = 0; j < 8; j++) if (T4[j] == s4) y = j;
        end else if ($countones(s4) == 1) begin
            err |= !r; nrd = 1'b0;
            if (s4 == 4'b1000) y = 7;
            for (int j = 0; j < 8; j++) if (~T4[j] == s4) y = j;
        end
        if (x < 0 || y < 0) err = 1'b1;
        b = {3'(y), 5'(x)};
    endfunction

    task automatic symbol_done();
        logic [7:0] b;
        logic [7:0] e;
        logic       err;
        logic       nrd;
        if (m_code == 10'b0011111010 || m_code == 10'b1100000101) begin
            check_eq("comma_rd", 64'(m_code[9]), 64'(m_rd));
            m_rd = !m_rd;
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end else begin
            decode(m_code, m_rd, b, err, nrd);
            check_eq("disparity", 64'(err), 64'(0));
            m_rd = nrd;
            run_len++;
            check_eq("data_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("data_byte", 64'(b), 64'(e));
                if (e == 8'hB5) check_eq("d21_5_code", 64'(m_code), 64'(10'b1010101010));
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            m_nb      = 0;
            m_started = 0;
            m_rd      = 1'b0;
            run_len   = 0;
        end else begin
            if (SYMBOL_START) begin
                if (m_started) check_eq("sym_period", 64'(m_nb), 64'(10));
                m_nb      = 0;
                m_started = 1;
            end
            if (m_started) begin
                m_code = {m_code[8:0], SER_OUT};
                m_nb++;
                if (m_nb == 10) symbol_done();
            end
        end
    end

    task automatic send_pkt(input logic [47:0] d, output int waited);
        @(negedge CLK);
        PKT_DATA  = d;
        PKT_VALID = 1'b1;
        waited    = 0;
        while (!PKT_READY && waited < 500) begin
            @(negedge CLK);
            waited++;
        end
        if (!PKT_READY) begin
            check_eq("ready_timeout", 64'(PKT_READY), 64'(1));
            PKT_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        for (int i = 5; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || run_len != 0) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check_eq("drain", 64'(exp_q.size() == 0 && run_len == 0), 64'(1));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] bits;
        logic [47:0] d;
        int          w;
        int          n;

        RST       = 1'b1;
        PKT_VALID = 1'b0;
        PKT_DATA  = '0;
        bits      = '0;
        repeat (3) @(negedge CLK);
        check_eq("rst_ser_out", 64'(SER_OUT), 64'(0));
        check_eq("rst_sym_start", 64'(SYMBOL_START), 64'(0));
        check_eq("rst_sync_done", 64'(SYNC_DONE), 64'(0));
        check_eq("rst_pkt_cnt", 64'(PKT_CNT), 64'(0));
        check_eq("rst_ready", 64'(PKT_READY), 64'(0));

        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            bits = {bits[18:0], SER_OUT};
            if (i == 0 || i == 10) check_eq("sym_start_hi", 64'(SYMBOL_START), 64'(1));
            if (i == 5) check_eq("sym_start_lo", 64'(SYMBOL_START), 64'(0));
            if (i == 9) check_eq("sync_early", 64'(SYNC_DONE), 64'(0));
            if (i == 10) check_eq("sync_done", 64'(SYNC_DONE), 64'(1));
        end
        check_eq("first_commas", 64'(bits), 64'(20'b0011111010_1100000101));

        send_pkt(48'hB5B5B5B5B5B5, w);
        PKT_VALID = 1'b0;
        drain();
        check_eq("run_single", 64'(last_run), 64'(6));
        check_eq("cnt_one", 64'(PKT_CNT), 64'(1));

        send_pkt(48'h000000000000, w);
        check_eq("ready_after_cap", 64'(PKT_READY), 64'(0));
        send_pkt(48'hB5B5B5B5B5B5, w);
        PKT_VALID = 1'b0;
        check_eq("b2b_ready_low", 64'(w >= 51 && w <= 60), 64'(1));
        drain();
        check_eq("run_b2b", 64'(last_run), 64'(12));
        check_eq("cnt_three", 64'(PKT_CNT), 64'(3));
        check_eq("sync_sticky", 64'(SYNC_DONE), 64'(1));

        send_pkt(48'h123456789ABC, w);
        PKT_VALID = 1'b0;
        n = 0;
        while (exp_q.size() > 4 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check_eq("reach_byte3", 64'(exp_q.size()), 64'(4));
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        exp_q.delete();
        check_eq("cnt_in_reset", 64'(PKT_CNT), 64'(0));
        check_eq("ready_in_reset", 64'(PKT_READY), 64'(0));
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            bits = {bits[18:0], SER_OUT};
            if (i == 0) check_eq("sync_cleared", 64'(SYNC_DONE), 64'(0));
        end
        check_eq("restart_comma", 64'(bits[9:0]), 64'(10'b0011111010));
        repeat (100) @(negedge CLK);
        check_eq("dropped_cnt", 64'(PKT_CNT), 64'(0));
        check_eq("dropped_ready", 64'(PKT_READY), 64'(1));

        for (int p = 0; p < 16; p++) begin
            d = {16'($urandom()), $urandom()};
            send_pkt(d, w);
        end
        PKT_VALID = 1'b0;
        drain();
        check_eq("cnt_wrap", 64'(PKT_CNT), 64'(0));

        for (int p = 0; p < 200; p++) begin
            d = {16'($urandom()), $urandom()};
            send_pkt(d, w);
            if ($urandom_range(0, 1) == 1) begin
                PKT_VALID = 1'b0;
                repeat ($urandom_range(1, 80)) @(negedge CLK);
            end
        end
        PKT_VALID = 1'b0;
        drain();
        check_eq("cnt_final", 64'(PKT_CNT), 64'(216 % 16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
